// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg
// Shared definitions for the immediate-extension stage and the decode-stage
// comparator.
// Contents:
//   EXT_MODE_W          width of the extension mode selector
//   EXT_SIGN..EXT_JUMP  mode encodings; codes 5..7 are undefined
//   ext_mode_defined()  true when a mode code names a real extension form
package imm_ext_pkg;

  localparam int EXT_MODE_W = 3;

  localparam logic [EXT_MODE_W-1:0] EXT_SIGN   = 3'd0;
  localparam logic [EXT_MODE_W-1:0] EXT_ZERO   = 3'd1;
  localparam logic [EXT_MODE_W-1:0] EXT_UPPER  = 3'd2;
  localparam logic [EXT_MODE_W-1:0] EXT_BRANCH = 3'd3;
  localparam logic [EXT_MODE_W-1:0] EXT_JUMP   = 3'd4;

  // Any code above EXT_JUMP is reserved and flagged as a mode error.
  function automatic logic ext_mode_defined(input logic [EXT_MODE_W-1:0] mode);
    return (mode <= EXT_JUMP);
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core
// Purely combinational immediate/index extension. Shared by the buffered
// extension stage and the decode-stage comparator.
// Parameters:
//   DATA_W  result width (>= IDX_W+2 and >= 2*IMM_W)
//   IMM_W   immediate width, taken from field[IMM_W-1:0]
//   IDX_W   jump index width, also the width of field
// Ports:
//   field     input   IDX_W       raw immediate/index bits
//   mode      input   EXT_MODE_W  extension mode
//   data      output  DATA_W      extended operand (0 for undefined modes)
//   mode_err  output  1           mode code is undefined
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int IDX_W  = 26
) (
  input  logic [IDX_W-1:0]      field,
  input  logic [EXT_MODE_W-1:0] mode,
  output logic [DATA_W-1:0]     data,
  output logic                  mode_err
);

  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] field_zext;

  // All candidate forms are built in parallel; the mode only picks one.
  assign imm        = field[IMM_W-1:0];
  assign imm_sext   = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zext   = {{(DATA_W-IMM_W){1'b0}}, imm};
  assign field_zext = DATA_W'(field);

  // Mode select. Branch offsets are shifted after sign extension, so any bits
  // pushed past the top of DATA_W simply fall off. Undefined modes produce a
  // zero operand plus the error flag so execute never sees garbage.
  always_comb begin
    data     = '0;
    mode_err = 1'b0;
    case (mode)
      EXT_SIGN:   data = imm_sext;
      EXT_ZERO:   data = imm_zext;
      EXT_UPPER:  data = {imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_BRANCH: data = imm_sext << 2;
      EXT_JUMP:   data = field_zext << 2;
      default:    mode_err = ~ext_mode_defined(mode);
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe
// Buffered immediate-extension stage between decode and execute. Extension
// is done combinationally on the way in; the result, tag and error flag are
// held in a 2-entry skid buffer so decode stalls and execute backpressure are
// decoupled. in_ready depends only on registered occupancy.
// Optional build macro: IMM_EXT_PERF_EN adds perf_count, a 32-bit count of
// accepted entries (cleared by reset only, not by flush).
// Ports:
//   clk           input   1           rising-edge clock
//   reset         input   1           asynchronous active-high reset
//   flush         input   1           synchronous squash of buffered/incoming
//   in_valid      input   1           producer has an entry
//   in_ready      output  1           stage can accept an entry
//   in_field      input   IDX_W       raw immediate/index bits
//   in_mode       input   EXT_MODE_W  extension mode
//   in_tag        input   TAG_W       sideband passed through unmodified
//   out_valid     output  1           head entry valid
//   out_ready     input   1           consumer takes head this cycle
//   out_data      output  DATA_W      extended operand of head (0 if empty)
//   out_tag       output  TAG_W       tag of head (0 if empty)
//   out_mode_err  output  1           head used an undefined mode (0 if empty)
//   perf_count    output  32          accepted-entry count (IMM_EXT_PERF_EN)
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int IDX_W  = 26,
  parameter int TAG_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      in_field,
  input  logic [EXT_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_mode_err
`ifdef IMM_EXT_PERF_EN
  ,
  output logic [31:0]           perf_count
`endif
);

  logic [DATA_W-1:0] ext_data;
  logic              ext_err;

  logic [DATA_W-1:0] data_q [2];
  logic [TAG_W-1:0]  tag_q  [2];
  logic              err_q  [2];

  logic [1:0] count_q;
  logic       rd_ptr_q;
  logic       wr_ptr_q;

  logic push;
  logic pop;

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .IDX_W  (IDX_W)
  ) u_core (
    .field    (in_field),
    .mode     (in_mode),
    .data     (ext_data),
    .mode_err (ext_err)
  );

  // Handshake qualification. A flush cycle swallows both the incoming entry
  // and any pop, so neither pointer nor count moves except via the clear.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Occupancy and ring pointers. With one entry held, a simultaneous push and
  // pop keeps the count at 1 while the head moves onto the new entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else if (flush) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Slot storage. Contents are only observed through the valid-gated output
  // mux, so the slots carry no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= ext_data;
      tag_q[wr_ptr_q]  <= in_tag;
      err_q[wr_ptr_q]  <= ext_err;
    end
  end

  // Head-entry outputs, forced to zero whenever the buffer is empty so stale
  // slot contents never leak to execute.
  always_comb begin
    out_data     = '0;
    out_tag      = '0;
    out_mode_err = 1'b0;
    if (out_valid) begin
      out_data     = data_q[rd_ptr_q];
      out_tag      = tag_q[rd_ptr_q];
      out_mode_err = err_q[rd_ptr_q];
    end
  end

`ifdef IMM_EXT_PERF_EN
  logic [31:0] perf_q;

  // Accepted-entry counter. Flush leaves it alone; it wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= 32'd0;
    end else if (push) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_count = perf_q;
`endif

endmodule
